// File: rtl/count_scheduler.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters.
// Optional abort-on-request-drop during RUN: define COUNT_SCHEDULER_ABORT_EN.
module count_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     target,
  output logic [NREQ-1:0]           grant,
  output logic                      busy,
  output logic [WIDTH-1:0]          count,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id
);

  // state | meaning
  // IDLE  | no owner; arbitrate among req starting at ptr
  // RUN   | counter owned by gidx, counting 0..tgt
  // DONE  | one-cycle completion pulse, grant still held
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [WIDTH-1:0] tgt;

  logic            sel_valid;
  logic [IW-1:0]   sel_idx;
  logic [IW:0]     cand;
  logic [IW-1:0]   nxt_ptr;

  // first set req bit searching ptr, ptr+1, ... with wrap
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!sel_valid && req[cand[IW-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    nxt_ptr = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      tgt     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (sel_valid) begin
            state <= RUN;
            busy  <= 1'b1;
            grant <= NREQ'(1) << sel_idx;
            gidx  <= sel_idx;
            count <= '0;
            tgt   <= target[sel_idx*WIDTH +: WIDTH];
          end
        end
        RUN: begin
`ifdef COUNT_SCHEDULER_ABORT_EN
          if (!req[gidx]) begin
            // treated like a completion for fairness, but silently
            state <= IDLE;
            busy  <= 1'b0;
            grant <= '0;
            count <= '0;
            ptr   <= nxt_ptr;
          end else if (count == tgt) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= gidx;
          end else begin
            count <= count + 1'b1;
          end
`else
          if (count == tgt) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= gidx;
          end else begin
            count <= count + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          grant <= '0;
          count <= '0;
          ptr   <= nxt_ptr;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          grant <= '0;
          count <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_scheduler.sv
// Scoreboard bench for count_scheduler: transaction-level round-robin model,
// monitor pops expected completions on every done pulse.
module tb_count_scheduler;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int TW    = NREQ * WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [TW-1:0]     target = '0;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [WIDTH-1:0]  count;
  logic              done;
  logic [$clog2(NREQ)-1:0] done_id;

  count_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .target(target),
    .grant(grant), .busy(busy), .count(count), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int tgt;} exp_t;
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   mp    = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // monitor
  initial begin
    logic pb;
    logic ppend;
    int   pc;
    int   gcnt;
    exp_t e;
    pb = 1'b0; ppend = 1'b0; pc = 0; gcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pb = 1'b0; ppend = 1'b0; gcnt = 0;
        continue;
      end
      chk("busy_vs_grant", int'(busy), int'(grant != '0));
      if (ppend) chk("req_to_grant", int'(grant != '0), 1);
      if (busy && !pb) begin
        chk("grant_onehot", $countones(grant), 1);
        chk("start_count", int'(count), 0);
        gcnt = 0;
      end else if (busy && pb) begin
        gcnt++;
        chk("count_step", int'(count), done ? pc : pc + 1);
      end
      if (!busy && pb) chk("idle_count", int'(count), 0);
      if (done) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done actual=id%0d expected=no_done", done_id);
        end else begin
          e = sbq.pop_front();
          chk("done_id", int'(done_id), e.id);
          chk("done_count", int'(count), e.tgt);
          chk("done_grant", int'(grant), 1 << e.id);
          chk("grant_to_done", gcnt, e.tgt + 1);
        end
      end
      ppend = !busy && (req != '0);
      pb = busy;
      pc = int'(count);
    end
  end

  task automatic run_round(input logic [NREQ-1:0] pat, input logic [TW-1:0] tv);
    int last;
    int i;
    int budget;
    logic [NREQ-1:0] pg;
    logic finished;
    target = tv;
    last = -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (mp + k) % NREQ;
      if (pat[i]) begin
        sbq.push_back('{i, int'(tv[i*WIDTH +: WIDTH])});
        last = i;
      end
    end
    if (last >= 0) mp = (last + 1) % NREQ;
    req = pat;
    pg = grant;
    budget = NREQ * ((1 << WIDTH) + 3) + 10;
    finished = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (grant != '0 && pg == '0) begin
        // a target change after the grant must not affect the run
        for (int j = 0; j < NREQ; j++)
          if (grant[j]) target[j*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      if (done) req[done_id] = 1'b0;
      pg = grant;
      if (req == '0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    chk("round_finished", int'(finished), 1);
    chk("sb_drain", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    logic [TW-1:0] tv;
    logic hit;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    rst = 1'b1;
    mp = 0;

    tv = '0; tv[2*WIDTH +: WIDTH] = 4'd5;
    run_round(4'b0100, tv);
    run_round(4'b1111, {NREQ{4'd1}});
    run_round(4'b1111, {NREQ{4'd15}});
    run_round(4'b1111, {NREQ{4'd0}});

    // reset mid-run at count 3 of a target-9 run
    target = '0; target[2*WIDTH +: WIDTH] = 4'd9;
    req = 4'b0100;
    hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (busy && count == 4'd3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_count3", int'(hit), 1);
    req = 4'b1111;
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_busy", int'(busy), 0);
    rst = 1'b1;
    mp = 0;
    run_round(4'b1111, 16'h2957);

    for (int r = 0; r < 25; r++)
      run_round(NREQ'($urandom_range(1, (1 << NREQ) - 1)), TW'($urandom));

    // requester 1 drops req at count 2
    target = '0; target[1*WIDTH +: WIDTH] = 4'd9;
`ifndef COUNT_SCHEDULER_ABORT_EN
    sbq.push_back('{1, 9});
`endif
    req = 4'b0010;
    hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (busy && count == 4'd2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_count2", int'(hit), 1);
    req = 4'b0000;
    @(posedge clk); #1;
`ifdef COUNT_SCHEDULER_ABORT_EN
    chk("abort_grant", int'(grant), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(count), 0);
`else
    chk("no_abort_grant", int'(grant), 2);
`endif
    hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (!busy) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("abort_settle", int'(hit), 1);
    chk("abort_sb_drain", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    mp = 2;
    run_round(4'b0011, TW'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_scheduler.md
# count_scheduler

Round-robin scheduler that shares a single internal up-counter among NREQ requesters. Each requester asks for a count run to its own terminal value. The block grants one requester at a time, counts from 0 up to the latched target, pulses `done` with the requester's index, then re-arbitrates. It sits between client logic and the up-counter datapath, replacing per-client counters with one sequenced resource.

## Interface
Parameters:
- `WIDTH`, 4, counter and target width in bits
- `NREQ`, 4, number of requesters (2..16)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `req`  in  NREQ  per-requester run request, level
- `target`  in  NREQ*WIDTH  terminal counts; slice i = `target[i*WIDTH +: WIDTH]`
- `grant`  out  NREQ  one-hot owner of the counter; 0 when idle
- `busy`  out  1  high whenever state ≠ IDLE
- `count`  out  WIDTH  current counter value
- `done`  out  1  one-cycle pulse: run completed
- `done_id`  out  $clog2(NREQ)  index of the completed requester; valid with `done`, otherwise holds its last value

## Operation
- States: IDLE, RUN, DONE.
- Internal priority pointer `ptr`, range 0..NREQ-1.
- IDLE:
  - If any `req` bit is high, select the first set bit searching `ptr`, `ptr`+1, … with wrap.
  - Next edge: enter RUN, set `grant` one-hot, set `count`=0, latch that requester's `target`.
  - If no `req` bit is high, stay in IDLE.
- RUN:
  - If `count` ≠ latched target, `count` increments each edge.
  - If `count` == latched target, next edge enters DONE, `count` holds and `done`=1.
  - Changes on `target` are ignored during RUN. `req` is ignored during RUN unless the abort feature is compiled in.
- DONE (exactly one cycle):
  - `done`=1, `done_id`=granted index, `grant` still asserted.
  - Next edge: enter IDLE, set `grant`=0, `count`=0, `ptr`=(granted index+1) mod NREQ.
- A requester that keeps `req` high after `done` stays eligible, but other active requesters are served first.
- `count` never wraps. The maximum target (2^WIDTH−1) ends exactly at that value.

## Timing
- Reset values (immediate on `rst`=0, independent of `clk`): state IDLE, `grant`=0, `busy`=0, `count`=0, `done`=0, `done_id`=0, `ptr`=0.
- Request to grant: 1 cycle. A `req` sampled high at edge k produces `grant` valid after edge k.
- A run with target T occupies T+1 RUN cycles (count 0..T) plus 1 DONE cycle.
- Grant to `done`: T+1 cycles.
- Minimum spacing between consecutive grants: T+3 cycles, including the IDLE cycle.
- Target 0: one RUN cycle with `count`=0, then DONE.
- Reset asserted mid-run: all outputs return to reset values immediately. No `done` is produced, and the interrupted requester must re-request.
- Simultaneous requests: exactly one grant per arbitration, in round-robin order starting at `ptr`.

## Configuration
- Macro: `COUNT_SCHEDULER_ABORT_EN`.
- Defined:
  - In RUN, if the granted requester's `req` is 0 at an edge, the next state is IDLE with `grant`=0 and `count`=0, and no `done` pulse.
  - `ptr` advances past the aborted index as if the run had completed.
- Undefined: `req` is not examined during RUN or DONE, and every granted run completes.

## Test plan
1. Reset: drive `rst`=0 mid-simulation with `req`=4'b1111 → `grant`=0, `busy`=0, `count`=0, `done`=0 immediately. Release → first grant is 4'b0001.
2. Single run: `req`=4'b0100, target[2]=5 → `grant`=4'b0100 after 1 cycle, `count` steps 0,1,2,3,4,5, `done`=1 with `done_id`=2 for one cycle, then `busy`=0 and `count`=0.
3. Round robin: `req`=4'b1111 held, all targets=1 → grants 0,1,2,3,0 in order. Each grant lasts 3 cycles, and grants are separated by 1 idle cycle.
4. Boundaries:
   - target=15 → `count` reaches 15, no wrap, `done` follows.
   - target=0 → `done` asserts 1 cycle after grant.
   - Changing `target` mid-run has no effect.
5. Reset mid-run: target=9, assert `rst`=0 at `count`=3 → all outputs 0 at once, no `done`. Re-request after release restarts at `count`=0.
6. Abort: requester 1 drops `req` at `count`=2.
   - With `COUNT_SCHEDULER_ABORT_EN`: next cycle `grant`=0, no `done`, next grant goes to index 2 or later.
   - Without the macro: the run completes to target, `done_id`=1.
